// File: rtl/tff_updown_counter_pkg.sv
// Shared definitions for the T flip-flop based up/down counter family.
package tff_updown_counter_pkg;

  // Values taken by the up_dn direction input.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Largest value representable in `width` bits. Valid for width 1..32.
  function automatic logic [31:0] max_value(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop stage: toggles on t, synchronous active-low clear.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  logic q_q;

  // Clear on reset, otherwise invert the stored bit whenever t is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter built from a chain of T flip-flops,
// with count enable, parallel load (clamped), terminal-count and wrap flags.
module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = max_value(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Modulus as a WIDTH-bit value so every compare stays WIDTH bits wide.
  localparam logic [WIDTH-1:0] MAX_W = MAX_COUNT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic             wrap_d;
  logic             wrap_q;

  // Next-state selection: reset > load > enabled step > hold. States above
  // MAX_W (only reachable without a reset) are treated like a wrap so the
  // counter falls back into range on the first enabled step.
  always_comb begin
    q_d    = q;
    wrap_d = 1'b0;
    if (!rst_n) begin
      q_d = ZERO_W;
    end else if (load) begin
      q_d = (d > MAX_W) ? MAX_W : d;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (q >= MAX_W) begin
          q_d    = ZERO_W;
          wrap_d = 1'b1;
        end else begin
          q_d = q + ONE_W;
        end
      end else begin
        if (q == ZERO_W || q > MAX_W) begin
          q_d    = MAX_W;
          wrap_d = 1'b1;
        end else begin
          q_d = q - ONE_W;
        end
      end
    end
  end

  // A stage toggles exactly when its bit differs between now and next.
  assign t = q ^ q_d;

  // One T flip-flop per counter bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  // Register the wrap event so it lines up with the wrapped count on q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  assign tc = en & ~load & ((up_dn & (q == MAX_W)) | (~up_dn & (q == ZERO_W)));

endmodule
